// File: rtl/corr_sync_detector_pkg.sv
// Shared definitions for corr_sync_detector.
// Contents: code length and default PN codes, the sample encoding constants,
// the FSM state type and the per-chip multiply used by the correlators.
package corr_sync_detector_pkg;

  localparam int CODE_LEN = 31;

  // Bit 1 = +1 chip, bit 0 = -1 chip; transmitted MSB first.
  localparam logic [CODE_LEN-1:0] REF_CODE  = 31'h7CD215D8;
  localparam logic [CODE_LEN-1:0] ORTH_CODE = 31'h0DD4259F;

  // Sample encoding; any other value is an erasure (0).
  localparam logic [1:0] POS = 2'b01;
  localparam logic [1:0] NEG = 2'b11;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Product of one input sample with one code chip, as a signed value.
  function automatic logic signed [7:0] chip_mul(input logic [1:0] s, input logic c);
    logic signed [7:0] v;
    v = (s == POS) ? 8'sd1 : ((s == NEG) ? -8'sd1 : 8'sd0);
    return c ? v : -v;
  endfunction

endpackage

// File: rtl/corr_sync_detector_pn_correlator.sv
// pn_correlator: combinational correlation of a sample window against a PN code.
// Ports:
//   window - CODE_LEN 2-bit samples, window[1:0] is the newest sample
//   corr   - signed sum over i of sample[i] * chip(CODE bit i), range -31..+31
module pn_correlator
  import corr_sync_detector_pkg::*;
#(
  parameter logic [CODE_LEN-1:0] CODE = REF_CODE
) (
  input  logic [2*CODE_LEN-1:0] window,
  output logic signed [7:0]     corr
);

  always_comb begin
    corr = 8'sd0;
    for (int i = 0; i < CODE_LEN; i++) begin
      corr = corr + chip_mul(window[2*i +: 2], CODE[i]);
    end
  end

endmodule

// File: rtl/corr_sync_detector.sv
// corr_sync_detector: PN-code packet synchronizer.
// Ports:
//   clk, reset_n (sync, active low), sig_in (2-bit sample)
//   ref_corr / orth_corr  - registered correlations against the two codes
//   threshold             - orth_corr squared
//   enable_demodulator, enable_symbol_clk - high while LOCKED
//   symbol_clk            - one-cycle strobe at symbol boundaries
//   addr / index          - sample index of the maximum peak / first detection
//
// state  | meaning
// SEARCH | waiting for a correlation candidate
// TRACK  | following the peak for SEARCH_WIN cycles to find the maximum
// LOCKED | issuing PACKET_SYMBOLS symbol strobes aligned to the maximum
module corr_sync_detector
  import corr_sync_detector_pkg::*;
#(
  parameter logic [CODE_LEN-1:0] REF  = REF_CODE,
  parameter logic [CODE_LEN-1:0] ORTH = ORTH_CODE,
  parameter int MIN_PEAK       = 20,
  parameter int THR_SCALE      = 2,
  parameter int SEARCH_WIN     = 8,
  parameter int PACKET_SYMBOLS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        sig_in,
  output logic signed [7:0] ref_corr,
  output logic signed [7:0] orth_corr,
  output logic [15:0]       threshold,
  output logic              enable_demodulator,
  output logic              enable_symbol_clk,
  output logic              symbol_clk,
  output logic [7:0]        addr,
  output logic [7:0]        index
);

  localparam logic signed [7:0] MIN_PEAK_S = 8'(MIN_PEAK);

  logic [2*CODE_LEN-1:0] window_q, window_d;
  logic [7:0]            sample_count_q, sample_count_d;
  logic [7:0]            corr_idx_q, corr_idx_d;
  logic signed [7:0]     ref_corr_q, ref_corr_d;
  logic signed [7:0]     orth_corr_q, orth_corr_d;
  logic [15:0]           threshold_q, threshold_d;
  state_e                state_q, state_d;
  logic signed [7:0]     peak_val_q, peak_val_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            index_q, index_d;
  logic [7:0]            track_cnt_q, track_cnt_d;
  logic [7:0]            since_peak_q, since_peak_d;
  logic [7:0]            phase_q, phase_d;
  logic [7:0]            pulse_cnt_q, pulse_cnt_d;
  logic                  symbol_clk_q, symbol_clk_d;

  logic signed [15:0]    orth_ext, orth_sq;
  logic signed [17:0]    ref_ext, ref_sq;
  logic [17:0]           thr_scaled;
  logic                  candidate;
  logic [7:0]            since_next;

  pn_correlator #(.CODE(REF)) u_ref_corr (
    .window (window_q),
    .corr   (ref_corr_d)
  );

  pn_correlator #(.CODE(ORTH)) u_orth_corr (
    .window (window_q),
    .corr   (orth_corr_d)
  );

  always_comb begin
    window_d       = {window_q[2*CODE_LEN-3:0], sig_in};
    sample_count_d = sample_count_q + 8'd1;
    // The correlation registered this edge uses the window whose newest
    // sample was taken one count earlier.
    corr_idx_d     = sample_count_q - 8'd1;
    orth_ext       = 16'(orth_corr_d);
    orth_sq        = orth_ext * orth_ext;
    threshold_d    = unsigned'(orth_sq);
  end

  always_comb begin
    ref_ext    = 18'(ref_corr_q);
    ref_sq     = ref_ext * ref_ext;
    thr_scaled = {2'b00, threshold_q} * 18'(THR_SCALE);
    candidate  = (ref_corr_q >= MIN_PEAK_S) && (unsigned'(ref_sq) > thr_scaled);
  end

  always_comb begin
    state_d      = state_q;
    peak_val_d   = peak_val_q;
    addr_d       = addr_q;
    index_d      = index_q;
    track_cnt_d  = track_cnt_q;
    since_peak_d = since_peak_q;
    phase_d      = phase_q;
    pulse_cnt_d  = pulse_cnt_q;
    symbol_clk_d = 1'b0;
    since_next   = since_peak_q + 8'd1;

    case (state_q)
      SEARCH: begin
        if (candidate) begin
          peak_val_d   = ref_corr_q;
          addr_d       = corr_idx_q;
          index_d      = corr_idx_q;
          track_cnt_d  = 8'd0;
          // Registered correlation trails its newest sample by two edges.
          since_peak_d = 8'd2;
          state_d      = TRACK;
        end
      end
      TRACK: begin
        if (ref_corr_q > peak_val_q) begin
          peak_val_d = ref_corr_q;
          addr_d     = corr_idx_q;
          since_next = 8'd2;
        end
        since_peak_d = since_next;
        track_cnt_d  = track_cnt_q + 8'd1;
        if (track_cnt_q == 8'(SEARCH_WIN - 1)) begin
          state_d     = LOCKED;
          phase_d     = (since_next >= 8'(CODE_LEN)) ? since_next - 8'(CODE_LEN) : since_next;
          pulse_cnt_d = 8'd0;
        end
      end
      LOCKED: begin
        // Leave one cycle after the last strobe so it is seen with enables high.
        if (pulse_cnt_q == 8'(PACKET_SYMBOLS)) begin
          state_d = SEARCH;
        end else if (phase_q == 8'(CODE_LEN - 1)) begin
          phase_d      = 8'd0;
          symbol_clk_d = 1'b1;
          pulse_cnt_d  = pulse_cnt_q + 8'd1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      window_q       <= '0;
      sample_count_q <= '0;
      corr_idx_q     <= '0;
      ref_corr_q     <= '0;
      orth_corr_q    <= '0;
      threshold_q    <= '0;
      state_q        <= SEARCH;
      peak_val_q     <= '0;
      addr_q         <= '0;
      index_q        <= '0;
      track_cnt_q    <= '0;
      since_peak_q   <= '0;
      phase_q        <= '0;
      pulse_cnt_q    <= '0;
      symbol_clk_q   <= 1'b0;
    end else begin
      window_q       <= window_d;
      sample_count_q <= sample_count_d;
      corr_idx_q     <= corr_idx_d;
      ref_corr_q     <= ref_corr_d;
      orth_corr_q    <= orth_corr_d;
      threshold_q    <= threshold_d;
      state_q        <= state_d;
      peak_val_q     <= peak_val_d;
      addr_q         <= addr_d;
      index_q        <= index_d;
      track_cnt_q    <= track_cnt_d;
      since_peak_q   <= since_peak_d;
      phase_q        <= phase_d;
      pulse_cnt_q    <= pulse_cnt_d;
      symbol_clk_q   <= symbol_clk_d;
    end
  end

  assign ref_corr           = ref_corr_q;
  assign orth_corr          = orth_corr_q;
  assign threshold          = threshold_q;
  assign enable_demodulator = (state_q == LOCKED);
  assign enable_symbol_clk  = (state_q == LOCKED);
  assign symbol_clk         = symbol_clk_q;
  assign addr               = addr_q;
  assign index              = index_q;

endmodule

// File: tb/tb_corr_sync_detector.sv
// Directed bench for corr_sync_detector. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point.
module tb_corr_sync_detector;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        sig_in = 2'b00;
  logic signed [7:0] ref_corr, orth_corr;
  logic [15:0]       threshold;
  logic              enable_demodulator, enable_symbol_clk, symbol_clk;
  logic [7:0]        addr, index;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [30:0] REF_C  = 31'h7CD215D8;
  localparam logic [30:0] ORTH_C = 31'h0DD4259F;

  corr_sync_detector dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sig_in             (sig_in),
    .ref_corr           (ref_corr),
    .orth_corr          (orth_corr),
    .threshold          (threshold),
    .enable_demodulator (enable_demodulator),
    .enable_symbol_clk  (enable_symbol_clk),
    .symbol_clk         (symbol_clk),
    .addr               (addr),
    .index              (index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] v);
    sig_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sig_in  = 2'b00;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Sends a code MSB first; bits at or above 31-nzero are sent as erasures.
  task automatic send_code(input logic [30:0] code, input bit negate, input int nzero);
    for (int i = 30; i >= 0; i--) begin
      if (i >= 31 - nzero) send(2'b00);
      else if (code[i] ^ negate) send(2'b01);
      else send(2'b11);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ref"},  {8'h00, ref_corr}, 16'h0000);
    chk({tag, "_orth"}, {8'h00, orth_corr}, 16'h0000);
    chk({tag, "_thr"},  threshold, 16'h0000);
    chk({tag, "_en"},   {14'h0, enable_demodulator, enable_symbol_clk}, 16'h0000);
    chk({tag, "_sym"},  {15'h0, symbol_clk}, 16'h0000);
    chk({tag, "_addr"}, {8'h00, addr}, 16'h0000);
    chk({tag, "_idx"},  {8'h00, index}, 16'h0000);
  endtask

  initial begin
    int quiet_bad;

    // Reset then 40 zeros.
    do_reset();
    chk_idle("rst");
    for (int i = 0; i < 40; i++) send(2'b00);
    chk_idle("zeros");

    // Negated reference: strong negative peak, no detection.
    do_reset();
    send_code(REF_C, 1'b1, 0);
    send(2'b00);
    chk("neg_ref",  {8'h00, ref_corr}, 16'h00E1);
    chk("neg_orth", {8'h00, orth_corr}, 16'h00F9);
    chk("neg_thr",  threshold, 16'd49);
    for (int i = 0; i < 12; i++) send(2'b00);
    chk("neg_en",  {15'h0, enable_demodulator}, 16'h0000);
    chk("neg_idx", {8'h00, index}, 16'h0000);

    // Orthogonal code: orth peak, reference below condition.
    do_reset();
    send_code(ORTH_C, 1'b0, 0);
    send(2'b00);
    chk("orth_orth", {8'h00, orth_corr}, 16'd31);
    chk("orth_thr",  threshold, 16'd961);
    chk("orth_ref",  {8'h00, ref_corr}, 16'd7);
    for (int i = 0; i < 12; i++) send(2'b00);
    chk("orth_en",  {15'h0, enable_demodulator}, 16'h0000);
    chk("orth_idx", {8'h00, index}, 16'h0000);

    // 12 chips erased: ref 19, just under MIN_PEAK.
    do_reset();
    send_code(REF_C, 1'b0, 12);
    send(2'b00);
    chk("z12_ref",  {8'h00, ref_corr}, 16'd19);
    chk("z12_orth", {8'h00, orth_corr}, 16'd3);
    chk("z12_thr",  threshold, 16'd9);
    for (int i = 0; i < 12; i++) send(2'b00);
    chk("z12_en",  {15'h0, enable_demodulator}, 16'h0000);
    chk("z12_idx", {8'h00, index}, 16'h0000);

    // 11 chips erased: ref 20, exactly MIN_PEAK, detects.
    do_reset();
    send_code(REF_C, 1'b0, 11);
    send(2'b00);
    chk("z11_ref",  {8'h00, ref_corr}, 16'd20);
    chk("z11_orth", {8'h00, orth_corr}, 16'd4);
    chk("z11_thr",  threshold, 16'd16);
    send(2'b00);
    chk("z11_idx",  {8'h00, index}, 16'd30);
    chk("z11_addr", {8'h00, addr}, 16'd30);
    for (int i = 0; i < 8; i++) send(2'b00);
    chk("z11_en", {14'h0, enable_demodulator, enable_symbol_clk}, 16'h0003);
    for (int i = 0; i < 5; i++) send(2'b00);

    // Reset while LOCKED.
    reset_n = 1'b0;
    send(2'b00);
    chk_idle("midrst");
    reset_n = 1'b1;

    // Full reference code from index 0 (sample count restarted by the reset).
    send_code(REF_C, 1'b0, 0);
    send(2'b00);
    chk("ref_ref",  {8'h00, ref_corr}, 16'd31);
    chk("ref_orth", {8'h00, orth_corr}, 16'd7);
    chk("ref_thr",  threshold, 16'd49);
    send(2'b00);
    chk("ref_idx",  {8'h00, index}, 16'd30);
    chk("ref_addr", {8'h00, addr}, 16'd30);
    for (int i = 0; i < 7; i++) send(2'b00);
    chk("ref_en_early", {15'h0, enable_demodulator}, 16'h0000);
    send(2'b00);
    chk("ref_en_rise", {14'h0, enable_demodulator, enable_symbol_clk}, 16'h0003);
    for (int p = 0; p < 16; p++) begin
      quiet_bad = 0;
      for (int j = 0; j < ((p == 0) ? 20 : 30); j++) begin
        send(2'b00);
        if (symbol_clk !== 1'b0 || enable_demodulator !== 1'b1) quiet_bad++;
      end
      chk($sformatf("gap%0d", p), 16'(quiet_bad), 16'h0000);
      send(2'b00);
      chk($sformatf("pulse%0d", p), {14'h0, symbol_clk, enable_demodulator}, 16'h0003);
    end
    send(2'b00);
    chk("ref_done_en",  {14'h0, enable_demodulator, enable_symbol_clk}, 16'h0000);
    chk("ref_done_sym", {15'h0, symbol_clk}, 16'h0000);
    chk("ref_hold",     {addr, index}, {8'd30, 8'd30});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_sync_detector.md
Name: corr_sync_detector

Overview:
- Single-clock packet synchronizer for a symbol-rate stream of ±1 samples.
- Slides a CODE_LEN window over the input and correlates it against a reference PN code and an orthogonal PN code every cycle.
- Squares the orthogonal correlation to form a noise threshold and detects the reference-correlation peak.
- On peak detection, enables the downstream demodulator and generates a symbol-rate strobe aligned to that peak.

Parameters:
- CODE_LEN, 31, chips per code and window length.
- REF_CODE, 31'h7CD215D8, reference code. Bit 1 = +1, bit 0 = -1. Transmitted MSB first.
- ORTH_CODE, 31'h0DD4259F, orthogonal code, same encoding.
- MIN_PEAK, 20, minimum signed ref_corr accepted as a candidate.
- THR_SCALE, 2, multiplier applied to the threshold in the compare.
- SEARCH_WIN, 8, cycles spent tracking the maximum after first detection. Must be < CODE_LEN.
- PACKET_SYMBOLS, 16, symbol strobes issued before returning to search.

Ports:
- clk, in, 1, sample clock (one sample per symbol).
- reset_n, in, 1, synchronous active-low reset.
- sig_in, in, 2 signed, input sample. 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0 (erasure).
- ref_corr, out, 8 signed, reference correlation.
- orth_corr, out, 8 signed, orthogonal correlation.
- threshold, out, 16 unsigned, orth_corr squared.
- enable_demodulator, out, 1, high while LOCKED.
- enable_symbol_clk, out, 1, high while LOCKED.
- symbol_clk, out, 1, one-cycle strobe at symbol boundaries.
- addr, out, 8, sample index of the maximum peak.
- index, out, 8, sample index of the first detection.

Behaviour:
- Reset (reset_n = 0 at posedge):
  - window cleared to zeros; sample_count = 0; state = SEARCH.
  - All outputs 0.
- Window and sample counter:
  - Each cycle sig_in is shifted into window[0]; window[i] moves to window[i+1]; window[CODE_LEN-1] is dropped.
  - sample_count is 8-bit, increments every cycle, and wraps 255 -> 0. The sample taken at count k has index k.
- Correlation:
  - ref_corr = sum over i of window[i] * chip(REF_CODE bit i), with bit 0 pairing with the newest sample.
  - orth_corr uses the same form with ORTH_CODE.
  - Range -31..+31, summed at full precision then registered.
  - Both are registered one cycle after the window update. threshold = orth_corr², registered in the same cycle.
  - Latency: sample clocked at edge t appears in ref_corr after edge t+1.
- Candidate condition, evaluated on the registered values:
  - ref_corr >= MIN_PEAK (signed compare), and
  - ref_corr² > THR_SCALE * threshold (unsigned, 18-bit compare).
- FSM state SEARCH:
  - On a candidate: latch peak_val = ref_corr; latch addr and index = index of the newest sample in the producing window; go to TRACK with track_cnt = 0.
- FSM state TRACK:
  - Each cycle, track_cnt increments.
  - If ref_corr > peak_val (strictly greater, so ties keep the earliest), update peak_val and addr, and reset the cycles-since-peak counter.
  - After SEARCH_WIN cycles, go to LOCKED. Initialise phase = cycles since the max sample, modulo CODE_LEN.
- FSM state LOCKED:
  - enable_demodulator = enable_symbol_clk = 1.
  - phase increments every cycle, and wraps CODE_LEN-1 -> 0.
  - symbol_clk = 1 in the cycle phase wraps to 0. The first pulse comes CODE_LEN samples after the max sample.
  - After PACKET_SYMBOLS pulses, go to SEARCH. addr and index hold their values.
  - Candidates are ignored while LOCKED.
- Reset mid-operation: returns to SEARCH with all state cleared.
- addr and index hold between detections.

Decomposition:
- Shared package holds:
  - default codes and CODE_LEN;
  - the sample-encoding constants (POS = 2'b01, NEG = 2'b11);
  - the state enum {SEARCH, TRACK, LOCKED}.
- One sub-module, pn_correlator (parameter CODE), instantiated twice:
  - once for the reference code;
  - once for the orthogonal code, sharing the window.
- Squaring, compare and FSM stay in the top.

Test Plan:
- Reset, then 40 zeros -> ref_corr = orth_corr = 0, threshold = 0, state SEARCH, all strobes 0.
- Feed REF_CODE MSB first from index 0, then zeros.
  - After the last chip: ref_corr = 31 and threshold = orth_corr² per the golden model.
  - Detection gives index = 30, addr = 30.
  - enable_demodulator rises SEARCH_WIN cycles later.
  - First symbol_clk comes 31 samples after index 30, then every 31 cycles for 16 pulses, then SEARCH.
- Feed the negated REF_CODE -> ref_corr = -31, no detection.
- Feed ORTH_CODE -> orth_corr = 31 and threshold = 961; ref_corr stays below the condition, so no lock.
- Zero out 12 chips of REF_CODE -> ref_corr = 19 < MIN_PEAK, no detection. Zeroing 11 chips -> 20, detection.
- Assert reset_n = 0 during LOCKED -> next cycle all outputs 0, state SEARCH, sample_count = 0.
